// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and line constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Even-parity bit for a data byte: makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side byte handshake and status flags of the UART receiver.
// Optional macro UART_RX_PARITY_EN adds the parerr flag.
interface uart_receiver_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] dataout;
  logic                      rxvalid;
  logic                      rxready;
  logic                      framerr;
  logic                      overrun;
  logic                      busy;
`ifdef UART_RX_PARITY_EN
  logic                      parerr;

  modport master (output dataout, rxvalid, framerr, overrun, busy, parerr, input rxready);
  modport slave  (input dataout, rxvalid, framerr, overrun, busy, parerr, output rxready);
`else
  modport master (output dataout, rxvalid, framerr, overrun, busy, input rxready);
  modport slave  (input dataout, rxvalid, framerr, overrun, busy, output rxready);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; resets to the
// idle (high) level so a line that is idle during reset never looks like a start.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling FSM with baud tick counter and valid/ready output.
// Optional macro UART_RX_PARITY_EN enables an even-parity bit and the parerr flag.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rxdatain,
  uart_receiver_if.master   rx_if
);

  localparam int                TICK_W   = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rxdatain),
    .o_sync  (rx_s)
  );

  uart_state_e               state_q,   state_d;
  logic [TICK_W-1:0]         tick_q,    tick_d;
  logic [2:0]                bit_q,     bit_d;
  logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
  logic [UART_DATA_BITS-1:0] dataout_q, dataout_d;
  logic                      rxvalid_q, rxvalid_d;
  logic                      framerr_q, framerr_d;
  logic                      overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                      parerr_q,  parerr_d;
  logic                      par_bad_q, par_bad_d;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dataout_q <= '0;
      rxvalid_q <= 1'b0;
      framerr_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parerr_q  <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dataout_q <= dataout_d;
      rxvalid_q <= rxvalid_d;
      framerr_q <= framerr_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parerr_q  <= parerr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dataout_d = dataout_q;
    rxvalid_d = rxvalid_q;
    framerr_d = 1'b0;
    overrun_d = overrun_q;
`ifdef UART_RX_PARITY_EN
    parerr_d  = 1'b0;
    par_bad_d = par_bad_q;
`endif

    if (rxvalid_q && rx_if.rxready) begin
      rxvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (rx_s != UART_IDLE_LEVEL) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        // A start bit that is high again at mid-bit was a glitch: drop it silently.
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          bit_d  = '0;
          state_d = (rx_s == 1'b0) ? ST_DATA : ST_IDLE;
        end
      end

      ST_DATA: begin
        if (tick_q == TICK_END) begin
          tick_d         = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q == TICK_END) begin
          tick_d    = '0;
          par_bad_d = (rx_s != uart_even_parity(shift_q));
          state_d   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        // Leave at mid-stop so the next start edge is never missed.
        if (tick_q == TICK_END) begin
          tick_d  = '0;
          state_d = ST_IDLE;
          if (rx_s == 1'b0) begin
            framerr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parerr_d = 1'b1;
`endif
          end else begin
            dataout_d = shift_q;
            rxvalid_d = 1'b1;
            if (rxvalid_q && !rx_if.rxready) begin
              overrun_d = 1'b1;
            end
          end
        end
      end

      default: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_if.dataout = dataout_q;
  assign rx_if.rxvalid = rxvalid_q;
  assign rx_if.framerr = framerr_q;
  assign rx_if.overrun = overrun_q;
  assign rx_if.busy    = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parerr  = parerr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver: drives serial frames and checks the byte handshake and flags.
// Parity scenario is included only when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic rxd;

  uart_receiver_if rx_if ();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rxdatain (rxd),
    .rx_if      (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_q[$];
  int         framerr_cnt = 0;
  int         parerr_cnt  = 0;
  bit         track_busy  = 0;
  int         low_run     = 0;
  int         max_low     = 0;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rxvalid && rx_if.rxready) begin
        rx_q.push_back(rx_if.dataout);
        $display("[%0t] rx byte accepted: %02h", $time, rx_if.dataout);
      end
      if (rx_if.framerr) framerr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (rx_if.parerr) parerr_cnt++;
`endif
      if (track_busy) begin
        if (rx_if.busy) low_run = 0;
        else begin
          low_run++;
          if (low_run > max_low) max_low = low_run;
        end
      end
    end
  end

  // All line drives happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line_bit(input logic v);
    rxd = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(uart_even_parity(b));
`endif
    line_bit(stop_bit);
    rxd = 1'b1;
    $display("[%0t] sent frame %02h stop=%0b", $time, b, stop_bit);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    framerr_cnt = 0;
    parerr_cnt  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rx_if.rxready = 1'b0;
    tick(3);
    checks++; if (rx_if.dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %02h want 00", rx_if.dataout); end
    checks++; if (rx_if.rxvalid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid: got %b want 0", rx_if.rxvalid); end
    checks++; if (rx_if.framerr !== 1'b0) begin errors++; $display("FAIL reset_framerr: got %b want 0", rx_if.framerr); end
    checks++; if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_if.overrun); end
    rst = 1'b0;
    tick(5);
    checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_if.busy); end
  endtask

  task automatic test_loopback();
    clear_mon();
    rx_if.rxready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_frame(8'b0101_1000, 1'b1);
      tick(150);
    end
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL loopback_count: got %0d want 3", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== 8'h58) begin errors++; $display("FAIL loopback_byte%0d: got %02h want 58", k, rx_q[k]); end
    end
    checks++; if (framerr_cnt + parerr_cnt !== 0 || rx_if.overrun !== 1'b0) begin
      errors++; $display("FAIL loopback_flags: framerr=%0d parerr=%0d overrun=%b want 0/0/0", framerr_cnt, parerr_cnt, rx_if.overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'hA5;
    clear_mon();
    low_run = 0; max_low = 0; track_busy = 1;
    for (int k = 0; k < 3; k++) send_frame(exp[k], 1'b1);
    track_busy = 0;
    tick(40);
    checks++; if (rx_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", rx_q.size()); end
    for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp[k]) begin errors++; $display("FAIL b2b_byte%0d: got %02h want %02h", k, rx_q[k], exp[k]); end
    end
    checks++; if (max_low >= CPB) begin errors++; $display("FAIL b2b_busy_gap: got %0d idle cycles want < %0d", max_low, CPB); end
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    clear_mon();
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rx_if.busy) saw_busy = 1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_detect: busy seen %b want 1", saw_busy); end
    checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy %b want 0", rx_if.busy); end
    checks++; if (rx_q.size() !== 0 || rx_if.rxvalid !== 1'b0 || framerr_cnt !== 0) begin
      errors++; $display("FAIL glitch_quiet: bytes=%0d rxvalid=%b framerr=%0d want 0/0/0", rx_q.size(), rx_if.rxvalid, framerr_cnt);
    end
  endtask

  task automatic test_framerr();
    clear_mon();
    send_frame(8'h3C, 1'b0);
    tick(60);
    checks++; if (framerr_cnt !== 1) begin errors++; $display("FAIL framerr_pulse: got %0d cycles want 1", framerr_cnt); end
    checks++; if (rx_q.size() !== 0 || rx_if.rxvalid !== 1'b0) begin
      errors++; $display("FAIL framerr_discard: bytes=%0d rxvalid=%b want 0/0", rx_q.size(), rx_if.rxvalid);
    end
    send_frame(8'h3C, 1'b1);
    tick(40);
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C) begin
      errors++; $display("FAIL framerr_recover: bytes=%0d first=%02h want 1 x 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    rx_if.rxready = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(50);
    checks++; if (rx_if.dataout !== 8'h11 || rx_if.rxvalid !== 1'b1 || rx_if.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_first: data=%02h valid=%b ovr=%b want 11/1/0", rx_if.dataout, rx_if.rxvalid, rx_if.overrun);
    end
    send_frame(8'h22, 1'b1);
    tick(30);
    checks++; if (rx_if.dataout !== 8'h22 || rx_if.rxvalid !== 1'b1 || rx_if.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_second: data=%02h valid=%b ovr=%b want 22/1/1", rx_if.dataout, rx_if.rxvalid, rx_if.overrun);
    end
    rx_if.rxready = 1'b1;
    tick(1);
    rx_if.rxready = 1'b0;
    tick(2);
    checks++; if (rx_if.rxvalid !== 1'b0 || rx_if.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_accept: valid=%b ovr=%b want 0/1", rx_if.rxvalid, rx_if.overrun);
    end
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h22) begin
      errors++; $display("FAIL overrun_handshake: accepted=%0d want 1 byte 22", rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    rx_if.rxready = 1'b1;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (rx_if.busy !== 1'b0 || rx_if.dataout !== 8'h00 || rx_if.overrun !== 1'b0 || rx_if.rxvalid !== 1'b0) begin
          errors++; $display("FAIL async_reset: busy=%b data=%02h ovr=%b valid=%b want 0/00/0/0",
                             rx_if.busy, rx_if.dataout, rx_if.overrun, rx_if.rxvalid);
        end
      end
    join
    tick(2);
    rst = 1'b0;
    tick(20);
    clear_mon();
    send_frame(8'hC3, 1'b1);
    tick(40);
    checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3 || framerr_cnt !== 0) begin
      errors++; $display("FAIL reset_recover: bytes=%0d first=%02h framerr=%0d want 1 x c3, 0",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, framerr_cnt);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    b = 8'h07;
    clear_mon();
    rx_if.rxready = 1'b1;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(~uart_even_parity(b));
    line_bit(1'b1);
    rxd = 1'b1;
    tick(40);
    checks++; if (parerr_cnt !== 1) begin errors++; $display("FAIL parity_pulse: got %0d cycles want 1", parerr_cnt); end
    checks++; if (rx_q.size() !== 0 || framerr_cnt !== 0) begin
      errors++; $display("FAIL parity_discard: bytes=%0d framerr=%0d want 0/0", rx_q.size(), framerr_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rx_if.rxready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_framerr();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a summary.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
